// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response bundle between EX and the iterative
//               multiply/divide unit. The master side issues operations and
//               flushes; the slave side reports busy, done and the result.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      func_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, func_i, op1_i, op2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, func_i, op1_i, op2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. One bit per cycle
//               shift-add multiply and restoring divide on magnitudes, with
//               sign fix-up at the end. Divide-by-zero and signed overflow
//               finish straight out of PREP.
//               Optional macro MULDIV_FAST_MUL_EN: multiplies use a single
//               combinational signed-extended multiplier and skip CALC.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_REM    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_func;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_a;        // multiplicand or divisor magnitude
    logic [2*XLEN:0]   r_acc;      // {high/remainder, low/quotient}
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;    // negate product / quotient
    logic              r_neg_r;    // negate remainder (dividend sign)
    logic [XLEN-1:0]   r_result;

    logic              w_busy;
    logic              w_done;

    // Operand classification (func bit 2 selects divide, bit 1 selects remainder)
    logic              w_is_div;
    logic              w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div0, w_ovf, w_special, w_fast;
    logic [XLEN-1:0]   w_spec_res;

    assign w_is_div = r_func[2];
    assign w_s1     = (r_func == c_MULH) || (r_func == c_MULHSU) ||
                      (r_func == c_DIV)  || (r_func == c_REM);
    assign w_s2     = (r_func == c_MULH) || (r_func == c_DIV) || (r_func == c_REM);
    assign w_neg1   = w_s1 & r_op1[XLEN-1];
    assign w_neg2   = w_s2 & r_op2[XLEN-1];
    assign w_mag1   = w_neg1 ? -r_op1 : r_op1;
    assign w_mag2   = w_neg2 ? -r_op2 : r_op2;

    assign w_div0   = w_is_div && (r_op2 == '0);
    assign w_ovf    = ((r_func == c_DIV) || (r_func == c_REM)) &&
                      (r_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_op2 == '1);
    assign w_special  = w_div0 | w_ovf;
    // Division by zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend, remainder = 0.
    assign w_spec_res = w_div0 ? (r_func[1] ? r_op1 : '1)
                               : (r_func[1] ? '0 : r_op1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN:0] w_x1, w_x2, w_fprod;
    assign w_x1    = {{(XLEN+1){w_neg1}}, r_op1};
    assign w_x2    = {{(XLEN+1){w_neg2}}, r_op2};
    assign w_fprod = w_x1 * w_x2;
    assign w_fast  = !r_func[2];
`else
    assign w_fast  = 1'b0;
`endif

    // One iteration of shift-add multiply (LSB first, shifting right)
    logic [XLEN:0]   w_msum, w_madd;
    logic [2*XLEN:0] w_mul_next;
    assign w_msum     = r_acc[2*XLEN:XLEN] + {1'b0, r_a};
    assign w_madd     = r_acc[0] ? w_msum : r_acc[2*XLEN:XLEN];
    assign w_mul_next = {1'b0, w_madd, r_acc[XLEN-1:1]};

    // One iteration of restoring divide (MSB first, shifting left)
    logic [2*XLEN:0] w_shift, w_div_next;
    logic [XLEN+1:0] w_diff;
    assign w_shift    = {r_acc[2*XLEN-1:0], 1'b0};
    assign w_diff     = {1'b0, w_shift[2*XLEN:XLEN]} - {2'b00, r_a};
    assign w_div_next = w_diff[XLEN+1] ? w_shift
                                       : {w_diff[XLEN:0], w_shift[XLEN-1:1], 1'b1};

    // Sign fix-up and word selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q, w_r, w_fix_res;
    assign w_prod    = r_neg_q ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    assign w_q       = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r       = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_res = w_is_div ? (r_func[1] ? w_r : w_q)
                                : ((r_func == c_MUL) ? w_prod[XLEN-1:0]
                                                     : w_prod[2*XLEN-1:XLEN]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and status outputs; flush returns to IDLE from anywhere
    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE);
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start_i && !bus.flush_i) w_next = S_PREP;
            S_PREP: begin
                if (bus.flush_i)     w_next = S_IDLE;
                else if (w_special)  w_next = S_DONE;
                else if (w_fast)     w_next = S_FIX;
                else                 w_next = S_CALC;
            end
            S_CALC: begin
                if (bus.flush_i)                        w_next = S_IDLE;
                else if (r_cnt == CNT_W'(XLEN - 1))     w_next = S_FIX;
            end
            S_FIX:  w_next = bus.flush_i ? S_IDLE : S_DONE;
            S_DONE: begin
                w_next = S_IDLE;
                w_done = !bus.flush_i;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, accumulator iteration, result write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func   <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (!bus.flush_i) begin
            case (r_state)
                S_IDLE: if (bus.start_i) begin
                    r_func <= bus.func_i;
                    r_op1  <= bus.op1_i;
                    r_op2  <= bus.op2_i;
                end
                S_PREP: begin
                    r_cnt   <= '0;
                    r_neg_q <= w_neg1 ^ w_neg2;
                    r_neg_r <= w_neg1;
                    if (w_is_div) begin
                        r_a   <= w_mag2;
                        r_acc <= {{(XLEN+1){1'b0}}, w_mag1};
                    end else begin
                        r_a   <= w_mag1;
                        r_acc <= {{(XLEN+1){1'b0}}, w_mag2};
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (w_fast) begin
                        r_acc   <= w_fprod;
                        r_neg_q <= 1'b0;
                    end
`endif
                    if (w_special) r_result <= w_spec_res;
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed bench for muldiv_unit. Stimulus pushes expected
//               result and latency into a scoreboard; a monitor pops and
//               compares on every done_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = XLEN + 3;
`endif
    localparam int DIV_LAT = XLEN + 3;
    localparam int SPC_LAT = 2;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] last_res = '0;
    logic        chk_idle_next = 1'b0;

    // Free-running edge counter used to measure latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each done_o pulse against the scoreboard head
    always @(negedge clk) begin
        if (chk_idle_next) begin
            chk_idle_next = 1'b0;
            check("busy low after done", {31'b0, bus.busy_o}, 32'd0);
        end
        if (rst_n && bus.done_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected done_o: got done with result 0x%08h, expected no pending op", bus.result_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " result"}, bus.result_o, mon_e.res);
                check({mon_e.name, " latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                check({mon_e.name, " busy at done"}, {31'b0, bus.busy_o}, 32'd1);
                last_res      = mon_e.res;
                chk_idle_next = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle timeout: got busy_o=1, expected 0 within 200 cycles");
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.func_i  = f;
        bus.op1_i   = a;
        bus.op2_i   = b;
        bus.start_i = 1'b1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        exp_t e;
        wait_idle();
        drive(f, a, b);
        e.res  = exp;
        e.acc  = cyc + 1;
        e.lat  = lat;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Main directed sequence
    initial begin
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.func_i  = '0;
        bus.op1_i   = '0;
        bus.op2_i   = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   {31'b0, bus.busy_o}, 32'd0);
        check("reset done",   {31'b0, bus.done_o}, 32'd0);
        check("reset result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL with a start pulse while busy that must be ignored
        issue(F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "MUL 7*-3");
        check("busy after accept", {31'b0, bus.busy_o}, 32'd1);
        @(negedge clk);
        drive(F_DIVU, 32'd9, 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;

        issue(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "MULHU -1*-1");
        issue(F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "MULH -1*-1");
        issue(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "MULHSU -1*ffffffff");
        issue(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "DIV -7/2");
        issue(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "REM -7/2");
        issue(F_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, "DIVU 100/7");
        issue(F_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, "REMU 100/7");
        issue(F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT, "DIV 5/0");
        issue(F_REM,    32'd5,        32'd0,        32'd5,        SPC_LAT, "REM 5/0");
        issue(F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT, "DIVU 5/0");
        issue(F_REMU,   32'd9,        32'd0,        32'd9,        SPC_LAT, "REMU 9/0");
        issue(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT, "DIV ovf");
        issue(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT, "REM ovf");

        // Flush mid-divide: no done, result held
        wait_idle();
        drive(F_DIVU, 32'd1000, 32'd3);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (8) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("busy after flush",   {31'b0, bus.busy_o}, 32'd0);
        check("result after flush", bus.result_o, last_res);
        repeat (40) @(negedge clk);

        // Flush beats start while idle
        drive(F_MUL, 32'd2, 32'd2);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush blocks accept", {31'b0, bus.busy_o}, 32'd0);

        issue(F_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, "MUL 3*4");

        // Asynchronous reset in the middle of an operation
        wait_idle();
        drive(F_DIVU, 32'd77, 32'd5);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy",   {31'b0, bus.busy_o}, 32'd0);
        check("async reset done",   {31'b0, bus.done_o}, 32'd0);
        check("async reset result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIVU after reset");

        begin
            int k = 0;
            while (sb.size() != 0 && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
